// File: rtl/ins_fetch.sv
// 8051 instruction fetch stage: program counter, byte-wide ROM req/ack reader,
// decoder hand-off with read_en pulse, and an illegal-opcode watchdog.
module ins_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        rom_req,
  output logic [15:0] rom_addr,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  input  logic        id_ready,
  output logic [7:0]  instruction,
  output logic [15:0] pc_out,
  output logic        read_en,
  input  logic        pc_load,
  input  logic [15:0] pc_new,
  output logic        ill_op
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    HOLD    = 3'd2,
    ISSUE   = 3'd3,
    WAIT_PC = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        rom_req_q, rom_req_d;
  logic [15:0] rom_addr_q, rom_addr_d;
  logic [7:0]  instruction_q, instruction_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        read_en_q, read_en_d;
  logic        ill_op_q, ill_op_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic [7:0]  cnt_q, cnt_d;

  // A live pc_load always overrides an older pending redirect.
  logic        redir_hit;
  logic [15:0] redir_pc;
  logic        wait_exit;
  logic [15:0] wait_nxt;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rom_req_d     = rom_req_q;
    rom_addr_d    = rom_addr_q;
    instruction_d = instruction_q;
    pc_out_d      = pc_out_q;
    read_en_d     = 1'b0;
    ill_op_d      = 1'b0;
    pend_vld_d    = pend_vld_q;
    pend_pc_d     = pend_pc_q;
    cnt_d         = cnt_q;
    redir_hit     = pc_load || pend_vld_q;
    redir_pc      = pc_load ? pc_new : pend_pc_q;
    wait_exit     = 1'b0;
    wait_nxt      = pc_q;

    case (state_q)
      IDLE: begin
        if (fetch_en) begin
          state_d    = FETCH;
          rom_req_d  = 1'b1;
          rom_addr_d = pc_q;
        end
      end

      FETCH: begin
        if (rom_req_q && rom_ack) begin
          if (redir_hit) begin
            // Stale byte is dropped; re-request at the redirect target.
            rom_addr_d = redir_pc;
            pc_d       = redir_pc;
            pend_vld_d = 1'b0;
          end else begin
            rom_req_d     = 1'b0;
            instruction_d = rom_data;
            pc_out_d      = rom_addr_q;
            if (id_ready) begin
              state_d   = ISSUE;
              read_en_d = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end else if (pc_load) begin
          pend_vld_d = 1'b1;
          pend_pc_d  = pc_new;
        end
      end

      HOLD: begin
        if (pc_load) begin
          pend_vld_d = 1'b1;
          pend_pc_d  = pc_new;
        end
        if (id_ready) begin
          state_d   = ISSUE;
          read_en_d = 1'b1;
        end
      end

      ISSUE: begin
        if (pc_load) begin
          pend_vld_d = 1'b1;
          pend_pc_d  = pc_new;
        end
        state_d = WAIT_PC;
        cnt_d   = 8'd0;
      end

      WAIT_PC: begin
        if (redir_hit) begin
          wait_exit = 1'b1;
          wait_nxt  = redir_pc;
        end else if (cnt_q == CNT_LAST) begin
          wait_exit = 1'b1;
          wait_nxt  = pc_out_q + 16'd1;
          ill_op_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end

        if (wait_exit) begin
          pc_d       = wait_nxt;
          pend_vld_d = 1'b0;
          if (fetch_en) begin
            state_d    = FETCH;
            rom_req_d  = 1'b1;
            rom_addr_d = wait_nxt;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      rom_req_q     <= 1'b0;
      rom_addr_q    <= RESET_PC;
      instruction_q <= 8'h00;
      pc_out_q      <= RESET_PC;
      read_en_q     <= 1'b0;
      ill_op_q      <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_pc_q     <= 16'h0000;
      cnt_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rom_req_q     <= rom_req_d;
      rom_addr_q    <= rom_addr_d;
      instruction_q <= instruction_d;
      pc_out_q      <= pc_out_d;
      read_en_q     <= read_en_d;
      ill_op_q      <= ill_op_d;
      pend_vld_q    <= pend_vld_d;
      pend_pc_q     <= pend_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign instruction = instruction_q;
  assign pc_out      = pc_out_q;
  assign read_en     = read_en_q;
  assign ill_op      = ill_op_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed test-plan scenarios plus randomized fetch
// transactions checked against a transaction-level model of the PC flow.
module tb_ins_fetch;
  localparam int TO   = 15;
  localparam int W_TO = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, fetch_en, rom_ack, id_ready, pc_load;
  logic [7:0]  rom_data;
  logic [15:0] pc_new;
  logic        rom_req, read_en, ill_op;
  logic [15:0] rom_addr, pc_out;
  logic [7:0]  instruction;

  logic        w_rst = 1'b1, w_fetch_en, w_rom_ack, w_id_ready, w_pc_load;
  logic [7:0]  w_rom_data;
  logic [15:0] w_pc_new;
  logic        w_rom_req, w_read_en, w_ill_op;
  logic [15:0] w_rom_addr, w_pc_out;
  logic [7:0]  w_instruction;

  ins_fetch #(.RESET_PC(16'h0000), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .rom_req(rom_req),
    .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .id_ready(id_ready), .instruction(instruction), .pc_out(pc_out),
    .read_en(read_en), .pc_load(pc_load), .pc_new(pc_new), .ill_op(ill_op)
  );

  ins_fetch #(.RESET_PC(16'hFFFF), .TIMEOUT(W_TO)) u_wrap (
    .clk(clk), .rst(w_rst), .fetch_en(w_fetch_en), .rom_req(w_rom_req),
    .rom_addr(w_rom_addr), .rom_ack(w_rom_ack), .rom_data(w_rom_data),
    .id_ready(w_id_ready), .instruction(w_instruction), .pc_out(w_pc_out),
    .read_en(w_read_en), .pc_load(w_pc_load), .pc_new(w_pc_new), .ill_op(w_ill_op)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          re_cnt = 0;
  int          issued = 0;
  logic        prev_re = 1'b0;
  time         t_req;
  time         t0;
  logic [15:0] ea;

  initial begin
    #400000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Every cycle advance goes through here so read_en pulses are tracked.
  task automatic cyc();
    prev_re = read_en;
    @(negedge clk);
    if (read_en === 1'b1) begin
      re_cnt++;
      check_val("read_en_gap", 32'(prev_re), 0);
    end
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (rom_req !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    check_val("req_seen", 32'(rom_req), 1);
    t_req = $time;
  endtask

  task automatic fetch_issue(inout logic [15:0] a, input logic [7:0] d_in,
                             input int ack_dly, input int rdy_dly,
                             input bit redir, input logic [15:0] rpc,
                             input bit hold_ld, input logic [15:0] hpc);
    logic [7:0] d;
    bit         done;
    d    = d_in;
    done = 1'b0;
    wait_req();
    for (int pass = 0; pass < 2 && !done; pass++) begin
      check_val("rom_addr", 32'(rom_addr), 32'(a));
      for (int w = 0; w < ack_dly; w++) begin
        if (redir && pass == 0 && w == ack_dly / 2) begin
          pc_load = 1'b1;
          pc_new  = rpc;
        end
        cyc();
        pc_load = 1'b0;
        check_val("req_held", 32'({rom_req, rom_addr}), 32'({1'b1, a}));
      end
      rom_ack  = 1'b1;
      rom_data = d;
      id_ready = (rdy_dly == 0);
      cyc();
      rom_ack  = 1'b0;
      rom_data = 8'($urandom);
      if (redir && pass == 0) begin
        check_val("redir_no_issue", 32'({read_en, rom_req}), 1);
        a = rpc;
        d = rom_byte(rpc);
      end else begin
        check_val("req_drop", 32'(rom_req), 0);
        if (rdy_dly > 0) begin
          for (int h = 0; h <= rdy_dly; h++) begin
            check_val("bp_read_en", 32'(read_en), 0);
            check_val("bp_instr", 32'(instruction), 32'(d));
            if (h == 0 && hold_ld) begin
              pc_load = 1'b1;
              pc_new  = hpc;
            end
            if (h == rdy_dly) id_ready = 1'b1;
            cyc();
            pc_load = 1'b0;
          end
        end
        check_val("read_en", 32'(read_en), 1);
        check_val("instruction", 32'(instruction), 32'(d));
        check_val("pc_out", 32'(pc_out), 32'(a));
        issued++;
        done = 1'b1;
      end
    end
  endtask

  // Entered on the read_en cycle. pmode: 0 none, 1 redirect already pending
  // from HOLD (target ppc), 2 pc_load=ppc driven during the read_en cycle.
  task automatic wait_pc(input int load_dly, input logic [15:0] np, input bit fe,
                         input int pmode, input logic [15:0] ppc, inout logic [15:0] a);
    int          n_wait;
    bit          exp_ill;
    logic [15:0] nxt;
    if (pmode != 0) begin
      n_wait  = 1;
      nxt     = (load_dly == 0) ? np : ppc;
      exp_ill = 1'b0;
    end else if (load_dly < TO) begin
      n_wait  = load_dly + 1;
      nxt     = np;
      exp_ill = 1'b0;
    end else begin
      n_wait  = TO;
      nxt     = a + 16'd1;
      exp_ill = 1'b1;
    end
    fetch_en = fe;
    if (pmode == 2) begin
      pc_load = 1'b1;
      pc_new  = ppc;
    end
    cyc();
    pc_load = 1'b0;
    for (int c = 0; c < n_wait; c++) begin
      check_val("wait_quiet", 32'({rom_req, read_en, ill_op}), 0);
      if (c == load_dly) begin
        pc_load = 1'b1;
        pc_new  = np;
      end
      rom_ack = 1'($urandom_range(0, 1));
      cyc();
      pc_load = 1'b0;
      rom_ack = 1'b0;
    end
    check_val("ill_op", 32'(ill_op), 32'(exp_ill));
    check_val("req_after_wait", 32'(rom_req), 32'(fe));
    if (fe) begin
      check_val("next_addr", 32'(rom_addr), 32'(nxt));
      if (exp_ill) begin
        cyc();
        check_val("ill_op_pulse", 32'(ill_op), 0);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        rom_ack = 1'($urandom_range(0, 1));
        cyc();
        rom_ack = 1'b0;
        check_val("halted", 32'({rom_req, ill_op}), 0);
      end
      fetch_en = 1'b1;
    end
    a = nxt;
  endtask

  initial begin
    int          ad, rd, ld, pm;
    bit          rdr, hl, fe;
    logic [15:0] rp, hp, np, pp;

    fetch_en = 1'b1; rom_ack = 1'b0; rom_data = 8'h00; id_ready = 1'b1;
    pc_load = 1'b0; pc_new = 16'h0000;
    w_fetch_en = 1'b1; w_rom_ack = 1'b0; w_rom_data = 8'h00; w_id_ready = 1'b1;
    w_pc_load = 1'b0; w_pc_new = 16'h0000;

    // Reset values
    cyc();
    cyc();
    check_val("rst_rom_req", 32'(rom_req), 0);
    check_val("rst_rom_addr", 32'(rom_addr), 0);
    check_val("rst_instruction", 32'(instruction), 0);
    check_val("rst_pc_out", 32'(pc_out), 0);
    check_val("rst_read_en", 32'(read_en), 0);
    check_val("rst_ill_op", 32'(ill_op), 0);
    rst = 1'b0;

    // First fetch, then 3-cycle turnaround with immediate pc_load
    ea = 16'h0000;
    fetch_issue(ea, 8'h04, 0, 0, 1'b0, 16'h0, 1'b0, 16'h0);
    t0 = t_req;
    wait_pc(0, 16'h0001, 1'b1, 0, 16'h0, ea);
    check_val("throughput", 32'(($time - t0) / 10), 3);

    // Watchdog
    fetch_issue(ea, 8'h02, 0, 0, 1'b0, 16'h0, 1'b0, 16'h0);
    wait_pc(TO + 5, 16'hBEEF, 1'b1, 0, 16'h0, ea);

    // Back-pressure
    fetch_issue(ea, 8'h74, 1, 5, 1'b0, 16'h0, 1'b0, 16'h0);
    wait_pc(2, 16'h1000, 1'b1, 0, 16'h0, ea);

    // Redirect during FETCH, then pc_load on the watchdog edge
    fetch_issue(ea, 8'hE4, 4, 0, 1'b1, 16'h0123, 1'b0, 16'h0);
    wait_pc(TO - 1, 16'h2000, 1'b1, 0, 16'h0, ea);

    // Halt: fetch_en dropped during FETCH
    fetch_en = 1'b0;
    fetch_issue(ea, 8'h12, 2, 0, 1'b0, 16'h0, 1'b0, 16'h0);
    wait_pc(1, 16'h3000, 1'b0, 0, 16'h0, ea);

    // Pending redirect captured in HOLD, then in ISSUE
    fetch_issue(ea, 8'h33, 0, 2, 1'b0, 16'h0, 1'b1, 16'h4000);
    wait_pc(5, 16'h5555, 1'b1, 1, 16'h4000, ea);
    fetch_issue(ea, 8'h44, 0, 0, 1'b0, 16'h0, 1'b0, 16'h0);
    wait_pc(3, 16'h6666, 1'b1, 2, 16'h4444, ea);

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      ad  = int'($urandom_range(0, 3));
      rd  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      rdr = (ad > 0) && ($urandom_range(0, 5) == 0);
      hl  = (rd > 0) && ($urandom_range(0, 4) == 0);
      rp  = 16'($urandom);
      hp  = 16'($urandom);
      np  = 16'($urandom);
      pp  = 16'($urandom);
      fetch_issue(ea, rom_byte(ea), ad, rd, rdr, rp, hl, hp);
      if (hl) begin
        pm = 1;
        pp = hp;
      end else begin
        pm = ($urandom_range(0, 6) == 0) ? 2 : 0;
      end
      ld = ($urandom_range(0, 3) == 0) ? TO + 3 : int'($urandom_range(0, TO - 1));
      fe = ($urandom_range(0, 7) != 0);
      wait_pc(ld, np, fe, pm, pp, ea);
    end

    // Async reset in WAIT_PC
    fetch_issue(ea, 8'hA5, 1, 0, 1'b0, 16'h0, 1'b0, 16'h0);
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    check_val("arst_rom_req", 32'(rom_req), 0);
    check_val("arst_rom_addr", 32'(rom_addr), 0);
    check_val("arst_instruction", 32'(instruction), 0);
    check_val("arst_pc_out", 32'(pc_out), 0);
    check_val("arst_read_en", 32'(read_en), 0);
    check_val("arst_ill_op", 32'(ill_op), 0);
    cyc();
    rst = 1'b0;

    // Async reset mid-handshake drops rom_req at once
    wait_req();
    #2 rst = 1'b1;
    #1;
    check_val("arst_fetch_req", 32'(rom_req), 0);
    cyc();
    rst = 1'b0;
    ea = 16'h0000;
    fetch_issue(ea, 8'h5C, 0, 0, 1'b0, 16'h0, 1'b0, 16'h0);
    wait_pc(0, 16'h0042, 1'b1, 0, 16'h0, ea);
    check_val("issue_count", 32'(re_cnt), 32'(issued));

    // Wrap instance: RESET_PC=FFFF
    cyc();
    w_rst = 1'b0;
    cyc();
    check_val("w_req", 32'(w_rom_req), 1);
    check_val("w_addr", 32'(w_rom_addr), 32'h0000FFFF);
    w_rom_ack = 1'b1; w_rom_data = 8'h00;
    cyc();
    w_rom_ack = 1'b0;
    check_val("w_read_en", 32'(w_read_en), 1);
    check_val("w_pc_out", 32'(w_pc_out), 32'h0000FFFF);
    check_val("w_instruction", 32'(w_instruction), 0);
    repeat (W_TO + 1) cyc();
    check_val("w_ill_op", 32'(w_ill_op), 1);
    check_val("w_wd_addr", 32'({w_rom_req, w_rom_addr}), 32'h00010000);
    w_rom_ack = 1'b1;
    cyc();
    w_rom_ack = 1'b0;
    check_val("w_pc_out0", 32'(w_pc_out), 0);
    cyc();
    w_pc_load = 1'b1; w_pc_new = 16'hFFFF;
    cyc();
    w_pc_load = 1'b0;
    check_val("w_load_ffff", 32'(w_rom_addr), 32'h0000FFFF);
    w_rom_ack = 1'b1;
    cyc();
    w_rom_ack = 1'b0;
    cyc();
    w_pc_load = 1'b1; w_pc_new = 16'h0000;
    cyc();
    w_pc_load = 1'b0;
    check_val("w_load_0000", 32'({w_rom_req, w_rom_addr}), 32'h00010000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
